// File: rtl/btn_pkg.sv
// rtl/btn_pkg.sv - shared state encoding and default timing constants for button lockout
package btn_pkg;

    // Per-channel FSM state encoding
    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_LOCK     = 2'd1;
    localparam logic [1:0] ST_REPEAT   = 2'd2;
    localparam logic [1:0] ST_WAIT_REL = 2'd3;

    // Defaults sized for a 100 MHz clock
    localparam int DEF_N_BTN         = 5;
    localparam int DEF_LOCK_CYCLES   = 10_000_000;
    localparam int DEF_REPEAT_CYCLES = 25_000_000;
    localparam int DEF_SHARED_LOCK   = 1;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Counter must hold the larger terminal value without wrapping
    function automatic int cnt_width(input int lock_cycles, input int repeat_cycles);
        return $clog2(max_int(lock_cycles, repeat_cycles) + 1);
    endfunction

endpackage

// File: rtl/btn_lockout_chan.sv
// rtl/btn_lockout_chan.sv - one button channel: synchroniser, lockout/repeat FSM and counter
module btn_lockout_chan
    import btn_pkg::*;
#(
    parameter int LOCK_CYCLES   = DEF_LOCK_CYCLES,
    parameter int REPEAT_CYCLES = DEF_REPEAT_CYCLES,
    parameter int CNT_W         = cnt_width(DEF_LOCK_CYCLES, DEF_REPEAT_CYCLES)
) (
    input  logic clock,
    input  logic reset_n,
    input  logic btn,
    input  logic repeat_en,
    input  logic shared_lock,
    output logic press,
    output logic locked
);

    localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_CYCLES - 1);
    localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);

    logic             s_meta;
    logic             s_sync;
    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             press_nxt;

    // Two-flop synchroniser for the raw asynchronous button level
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            s_meta <= 1'b0;
            s_sync <= 1'b0;
        end else begin
            s_meta <= btn;
            s_sync <= s_meta;
        end
    end

    // Next-state, counter and press decision from the synchronised level
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        press_nxt = 1'b0;
        case (state)
            ST_IDLE: begin
                if (s_sync) begin
                    if (shared_lock) begin
                        // Another channel holds the shared lock: swallow this press
                        state_nxt = ST_WAIT_REL;
                    end else begin
                        press_nxt = 1'b1;
                        cnt_nxt   = '0;
                        state_nxt = ST_LOCK;
                    end
                end
            end
            ST_LOCK: begin
                if (cnt == LOCK_LAST) begin
                    cnt_nxt = '0;
                    if (!s_sync) begin
                        state_nxt = ST_IDLE;
                    end else if (repeat_en) begin
                        state_nxt = ST_REPEAT;
                    end else begin
                        state_nxt = ST_WAIT_REL;
                    end
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            ST_REPEAT: begin
                // Release or repeat disable wins over a coincident repeat pulse
                if (!s_sync) begin
                    cnt_nxt   = '0;
                    state_nxt = ST_IDLE;
                end else if (!repeat_en) begin
                    cnt_nxt   = '0;
                    state_nxt = ST_WAIT_REL;
                end else if (cnt == REP_LAST) begin
                    press_nxt = 1'b1;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            ST_WAIT_REL: begin
                if (!s_sync) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                cnt_nxt   = '0;
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // State, counter and registered outputs; locked tracks the LOCK state exactly
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            press  <= 1'b0;
            locked <= 1'b0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            press  <= press_nxt;
            locked <= (state_nxt == ST_LOCK);
        end
    end

endmodule

// File: rtl/btn_lockout_array.sv
// rtl/btn_lockout_array.sv - array of debounced/locked-out button channels with optional shared lock
module btn_lockout_array
    import btn_pkg::*;
#(
    parameter int N_BTN         = DEF_N_BTN,
    parameter int LOCK_CYCLES   = DEF_LOCK_CYCLES,
    parameter int REPEAT_CYCLES = DEF_REPEAT_CYCLES,
    parameter int SHARED_LOCK   = DEF_SHARED_LOCK
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [N_BTN-1:0] btn,
    input  logic [N_BTN-1:0] repeat_en,
    output logic [N_BTN-1:0] press,
    output logic [N_BTN-1:0] locked,
    output logic             ready
);

    localparam int CNT_W = cnt_width(LOCK_CYCLES, REPEAT_CYCLES);

    // Both terminal counts are compared as value-1, so each must be at least 2
    if (LOCK_CYCLES < 2 || REPEAT_CYCLES < 2) begin : g_param_check
        $error("btn_lockout_array: LOCK_CYCLES and REPEAT_CYCLES must be >= 2");
    end

    logic shared_lock;

    // Any channel in LOCK blocks new presses on all channels when sharing is enabled
    assign shared_lock = (SHARED_LOCK != 0) && (|locked);

    // Ready derives straight from the registered lock flags, so it moves with the state
    assign ready = ~|locked;

    for (genvar i = 0; i < N_BTN; i++) begin : g_chan
        btn_lockout_chan #(
            .LOCK_CYCLES   (LOCK_CYCLES),
            .REPEAT_CYCLES (REPEAT_CYCLES),
            .CNT_W         (CNT_W)
        ) u_chan (
            .clock       (clock),
            .reset_n     (reset_n),
            .btn         (btn[i]),
            .repeat_en   (repeat_en[i]),
            .shared_lock (shared_lock),
            .press       (press[i]),
            .locked      (locked[i])
        );
    end

endmodule

// File: tb/tb_btn_lockout_array.sv
// tb/tb_btn_lockout_array.sv - scoreboard bench for btn_lockout_array, per-channel and shared lock
module tb_btn_lockout_array;

    typedef struct {
        int         rel;
        logic [3:0] mask;
    } exp_t;

    logic       clk;
    logic       rst0_n, rst1_n;
    logic [3:0] btn0, btn1, ren0, ren1;
    logic [3:0] press0, press1, locked0, locked1;
    logic       rdy0, rdy1;

    exp_t q0[$];
    exp_t q1[$];
    int   edges = 0;
    int   base0 = 0;
    int   base1 = 0;
    int   lk0[4];
    int   lk1[4];
    int   nr0 = 0;
    int   nr1 = 0;
    int   vectors = 0;
    int   errors = 0;

    btn_lockout_array #(
        .N_BTN(4), .LOCK_CYCLES(10), .REPEAT_CYCLES(4), .SHARED_LOCK(0)
    ) dut0 (
        .clock(clk), .reset_n(rst0_n), .btn(btn0), .repeat_en(ren0),
        .press(press0), .locked(locked0), .ready(rdy0)
    );

    btn_lockout_array #(
        .N_BTN(4), .LOCK_CYCLES(10), .REPEAT_CYCLES(4), .SHARED_LOCK(1)
    ) dut1 (
        .clock(clk), .reset_n(rst1_n), .btn(btn1), .repeat_en(ren1),
        .press(press1), .locked(locked1), .ready(rdy1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) edges <= edges + 1;

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic wait_edges(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    function automatic exp_t mk(input int rel, input logic [3:0] mask);
        exp_t e;
        e.rel  = rel;
        e.mask = mask;
        return e;
    endfunction

    // Monitor dut0: every press pulse is matched against the scoreboard head
    always @(negedge clk) begin : mon0
        exp_t e;
        if (rst0_n) begin
            if (press0 !== 4'b0) begin
                if (q0.size() == 0) begin
                    vectors++;
                    errors++;
                    $display("FAIL dut0_unexpected_press: got mask %b at cycle %0d expected none", press0, edges - base0);
                end else begin
                    e = q0.pop_front();
                    check("dut0_press_cycle", edges - base0, e.rel);
                    check("dut0_press_mask", int'(press0), int'(e.mask));
                end
            end
            for (int i = 0; i < 4; i++) if (locked0[i] === 1'b1) lk0[i]++;
            if (rdy0 !== 1'b1) nr0++;
        end
    end

    // Monitor dut1
    always @(negedge clk) begin : mon1
        exp_t e;
        if (rst1_n) begin
            if (press1 !== 4'b0) begin
                if (q1.size() == 0) begin
                    vectors++;
                    errors++;
                    $display("FAIL dut1_unexpected_press: got mask %b at cycle %0d expected none", press1, edges - base1);
                end else begin
                    e = q1.pop_front();
                    check("dut1_press_cycle", edges - base1, e.rel);
                    check("dut1_press_mask", int'(press1), int'(e.mask));
                end
            end
            for (int i = 0; i < 4; i++) if (locked1[i] === 1'b1) lk1[i]++;
            if (rdy1 !== 1'b1) nr1++;
        end
    end

    task automatic clear_stats();
        for (int i = 0; i < 4; i++) begin
            lk0[i] = 0;
            lk1[i] = 0;
        end
        nr0 = 0;
        nr1 = 0;
    endtask

    initial begin
        rst0_n = 1'b0;
        rst1_n = 1'b0;
        btn0 = '0; btn1 = '0; ren0 = '0; ren1 = '0;
        clear_stats();
        wait_edges(3);
        check("rst_press0", int'(press0), 0);
        check("rst_locked0", int'(locked0), 0);
        check("rst_ready0", int'(rdy0), 1);
        check("rst_press1", int'(press1), 0);
        check("rst_locked1", int'(locked1), 0);
        check("rst_ready1", int'(rdy1), 1);
        rst0_n = 1'b1;
        rst1_n = 1'b1;
        wait_edges(2);

        // Single press, per-channel lock
        clear_stats();
        base0 = edges;
        q0.push_back(mk(3, 4'b0001));
        btn0 = 4'b0001;
        wait_edges(3);
        btn0 = 4'b0000;
        wait_edges(20);
        check("single_lock_len", lk0[0], 10);
        check("single_not_ready", nr0, 10);
        check("single_ready_end", int'(rdy0), 1);
        check("single_q_empty", q0.size(), 0);

        // Auto-repeat on channel 1
        clear_stats();
        ren0 = 4'b0010;
        base0 = edges;
        q0.push_back(mk(3, 4'b0010));
        q0.push_back(mk(17, 4'b0010));
        q0.push_back(mk(21, 4'b0010));
        q0.push_back(mk(25, 4'b0010));
        q0.push_back(mk(29, 4'b0010));
        btn0 = 4'b0010;
        wait_edges(30);
        btn0 = 4'b0000;
        wait_edges(15);
        ren0 = 4'b0000;
        check("repeat_lock_len", lk0[1], 10);
        check("repeat_q_empty", q0.size(), 0);

        // Hold without repeat: one pulse, then wait for release
        clear_stats();
        base0 = edges;
        q0.push_back(mk(3, 4'b0100));
        btn0 = 4'b0100;
        wait_edges(30);
        btn0 = 4'b0000;
        wait_edges(15);
        check("hold_lock_len", lk0[2], 10);
        check("hold_q_empty", q0.size(), 0);

        // Shared lock: second button during lock is swallowed, re-press later works
        clear_stats();
        base1 = edges;
        q1.push_back(mk(3, 4'b0001));
        btn1 = 4'b0001;
        wait_edges(4);
        btn1 = 4'b1001;
        wait_edges(2);
        btn1 = 4'b1000;
        wait_edges(4);
        btn1 = 4'b0000;
        wait_edges(10);
        q1.push_back(mk(23, 4'b1000));
        btn1 = 4'b1000;
        wait_edges(3);
        btn1 = 4'b0000;
        wait_edges(20);
        check("shared_lock0_len", lk1[0], 10);
        check("shared_lock3_len", lk1[3], 10);
        check("shared_q_empty", q1.size(), 0);

        // Simultaneous presses under shared lock
        clear_stats();
        base1 = edges;
        q1.push_back(mk(3, 4'b0011));
        btn1 = 4'b0011;
        wait_edges(3);
        btn1 = 4'b0000;
        wait_edges(20);
        check("simul_not_ready", nr1, 10);
        check("simul_lock0_len", lk1[0], 10);
        check("simul_lock1_len", lk1[1], 10);
        check("simul_q_empty", q1.size(), 0);

        // Reset at lock count 5 with button still held
        clear_stats();
        base0 = edges;
        q0.push_back(mk(3, 4'b0001));
        btn0 = 4'b0001;
        wait_edges(8);
        check("midlock_locked", int'(locked0), 1);
        rst0_n = 1'b0;
        #1;
        check("midrst_press", int'(press0), 0);
        check("midrst_locked", int'(locked0), 0);
        check("midrst_ready", int'(rdy0), 1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst0_n = 1'b1;
        base0 = edges;
        q0.push_back(mk(3, 4'b0001));
        wait_edges(8);
        btn0 = 4'b0000;
        wait_edges(20);
        check("postrst_q_empty", q0.size(), 0);
        check("postrst_ready", int'(rdy0), 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/btn_lockout_array.md
BTN_LOCKOUT_ARRAY -- requirements
Module: btn_lockout_array

Interface
REQ-001 SHALL have parameter N_BTN, default 5: number of button channels.
REQ-002 SHALL have parameter LOCK_CYCLES, default 10_000_000: lockout length in clock cycles (100 ms at 100 MHz).
REQ-003 SHALL have parameter REPEAT_CYCLES, default 25_000_000: auto-repeat period in clock cycles.
REQ-004 SHALL have parameter SHARED_LOCK, default 1: 1 means one press locks all channels; 0 means per-channel lockout.
REQ-005 SHALL have port clock  input  1  system clock; all logic on its rising edge.
REQ-006 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port btn  input  N_BTN  raw asynchronous button levels, active-high.
REQ-008 SHALL have port repeat_en  input  N_BTN  per-channel auto-repeat enable, sampled every cycle.
REQ-009 SHALL have port press  output  N_BTN  one-cycle press pulse per channel.
REQ-010 SHALL have port locked  output  N_BTN  per-channel lockout-active flag.
REQ-011 SHALL have port ready  output  1  high when no channel is in LOCK.

Function
REQ-012 SHALL synchronise each btn bit through two flops; all decisions use the synchronised level s[i].
REQ-013 SHALL run one FSM per channel with states IDLE, LOCK, REPEAT and WAIT_REL.
REQ-014 SHALL, in IDLE when s[i]=1 and no shared lock is active, assert press[i] for exactly one cycle, clear the counter and enter LOCK.
REQ-015 SHALL, in LOCK, increment the counter each cycle; when count == LOCK_CYCLES-1 it exits to IDLE if s[i]=0, to REPEAT if s[i]=1 and repeat_en[i]=1, otherwise to WAIT_REL.
REQ-016 SHALL, in REPEAT, count to REPEAT_CYCLES-1, then pulse press[i] for one cycle and restart the count; s[i]=0 or repeat_en[i]=0 returns the channel to IDLE (or WAIT_REL while s[i]=1) with no pulse.
REQ-017 SHALL, in WAIT_REL, return to IDLE on the first cycle with s[i]=0; no pulses occur in this state.
REQ-018 SHALL, when SHARED_LOCK=1, treat a shared lock as active while any channel is in LOCK; a channel in IDLE that sees s[i]=1 during a shared lock enters WAIT_REL with no pulse.
REQ-019 SHALL, when SHARED_LOCK=1 and several channels rise in the same cycle from an all-IDLE condition, pulse all of them and lock all of them together.
REQ-020 SHALL drive locked[i]=1 exactly when channel i is in LOCK; ready = ~|locked, registered with the state.
REQ-021 SHALL size the counter to $clog2(max(LOCK_CYCLES,REPEAT_CYCLES)+1) bits; it never wraps, and the terminal compare is equality.
REQ-022 SHALL produce press one cycle after the state register sees s[i]: btn edge to press is 3 cycles.
REQ-023 SHALL require LOCK_CYCLES >= 2 and REPEAT_CYCLES >= 2 (elaboration-time check).

Reset
REQ-024 SHALL, while reset_n=0, put all FSMs in IDLE and drive counters=0, synchroniser flops=0, press=0, locked=0, ready=1.
REQ-025 SHALL, if reset is asserted mid-LOCK or mid-REPEAT, abort immediately; a button still held after release of reset produces a fresh press after synchronisation.

Structure
REQ-026 SHALL place the state encoding (IDLE, LOCK, REPEAT, WAIT_REL) and the default cycle constants in shared package btn_pkg.
REQ-027 SHALL implement one channel as sub-module btn_lockout_chan, instantiated N_BTN times by a generate loop; the shared-lock OR and ready live in the top.

Verification (LOCK_CYCLES=10, REPEAT_CYCLES=4, N_BTN=4)
REQ-028 SHALL test a single press: with SHARED_LOCK=0, btn[0] high 3 cycles then low -> press[0] one pulse at cycle 3, locked[0] high 10 cycles, then IDLE, ready back to 1.
REQ-029 SHALL test auto-repeat: btn[1] held 30 cycles with repeat_en[1]=1 -> press[1] at cycle 3, then every 4 cycles after lock ends (cycles 17, 21, 25, 29), none after release.
REQ-030 SHALL test hold without repeat: btn[2] held 30 cycles with repeat_en=0 -> one pulse, WAIT_REL until release, no further pulses.
REQ-031 SHALL test the shared lock: with SHARED_LOCK=1, btn[0] pressed, then btn[3] pressed 4 cycles later -> only press[0]; btn[3] re-pressed after release and after lock expiry -> press[3].
REQ-032 SHALL test simultaneous presses: with SHARED_LOCK=1, btn[0] and btn[1] rise in the same cycle -> both pulse in the same cycle and ready=0 for 10 cycles.
REQ-033 SHALL test reset mid-lock: reset_n low for 2 cycles at lock count 5 -> outputs at reset values immediately; a held btn yields a new press 3 cycles after reset_n rises.
